// File: rtl/i2c_sensor_poller_if.sv
// Handshake between the sensor poller and the single-byte I2C read-frame engine.
interface i2c_sensor_poller_if;
  logic       en_read;
  logic       start_frame;
  logic       stop_frame;
  logic       rd_done;
  logic [7:0] rd_data;

  modport master (
    output en_read,
    output start_frame,
    output stop_frame,
    input  rd_done,
    input  rd_data
  );

  modport slave (
    input  en_read,
    input  start_frame,
    input  stop_frame,
    output rd_done,
    output rd_data
  );
endinterface

// File: rtl/i2c_sensor_poller.sv
// Periodic two-byte read sequencer: issues two frames per period, assembles a
// 16-bit MSB-first sample, publishes it with a one-cycle pulse, flags timeouts.
module i2c_sensor_poller #(
  parameter int unsigned PERIOD_US   = 100000,
  parameter int unsigned GAP_US      = 50,
  parameter int unsigned TIMEOUT_US  = 2000,
  parameter logic [15:0] CNT_RST_VAL = 16'h0000
) (
  input  logic                       clk_1MHz,
  input  logic                       rst_n,
  input  logic                       enable,
  i2c_sensor_poller_if.master        rd_bus,
  output logic [15:0]                result,
  output logic                       result_valid,
  output logic                       timeout_err,
  output logic                       busy,
  output logic [15:0]                sample_cnt
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_GAP         = 3'd1,
    S_ISSUE       = 3'd2,
    S_WAIT_DONE   = 3'd3,
    S_NEXT        = 3'd4,
    S_PUBLISH     = 3'd5,
    S_WAIT_PERIOD = 3'd6
  } state_e;

  localparam logic [20:0] PERIOD_LAST = 21'(PERIOD_US - 32'd1);
  localparam logic [20:0] GAP_LAST    = 21'(GAP_US - 32'd1);
  localparam logic [20:0] TO_LAST     = 21'(TIMEOUT_US - 32'd1);
  localparam logic [20:0] CNT_MAX     = 21'h1F_FFFF;

  state_e      state_q, state_d;
  logic        idx_q, idx_d;
  logic [20:0] per_cnt_q, per_cnt_d;
  logic [20:0] gap_cnt_q, gap_cnt_d;
  logic [20:0] frm_cnt_q, frm_cnt_d;
  logic        rd_done_prev_q, rd_done_prev_d;
  logic [7:0]  byte0_q, byte0_d;
  logic [7:0]  byte1_q, byte1_d;
  logic        abort_q, abort_d;
  logic [15:0] result_q, result_d;
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        en_read_q, en_read_d;
  logic        start_frame_q, start_frame_d;
  logic        stop_frame_q, stop_frame_d;
  logic        result_valid_q, result_valid_d;
  logic        busy_q, busy_d;
  logic        rd_rise_s;
  logic        frame_to_s;
  logic        sample_start_s;

  assign rd_rise_s      = rd_bus.rd_done & ~rd_done_prev_q;
  assign frame_to_s     = (state_q == S_WAIT_DONE) && !rd_rise_s && (frm_cnt_q >= TO_LAST);
  assign sample_start_s = (state_d == S_GAP) &&
                          ((state_q == S_IDLE) || (state_q == S_WAIT_PERIOD));

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_1MHz) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= 1'b0;
      per_cnt_q      <= 21'd0;
      gap_cnt_q      <= 21'd0;
      frm_cnt_q      <= 21'd0;
      rd_done_prev_q <= 1'b0;
      byte0_q        <= 8'h00;
      byte1_q        <= 8'h00;
      abort_q        <= 1'b0;
      result_q       <= 16'h0000;
      sample_cnt_q   <= CNT_RST_VAL;
      timeout_err_q  <= 1'b0;
      en_read_q      <= 1'b0;
      start_frame_q  <= 1'b0;
      stop_frame_q   <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      per_cnt_q      <= per_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      frm_cnt_q      <= frm_cnt_d;
      rd_done_prev_q <= rd_done_prev_d;
      byte0_q        <= byte0_d;
      byte1_q        <= byte1_d;
      abort_q        <= abort_d;
      result_q       <= result_d;
      sample_cnt_q   <= sample_cnt_d;
      timeout_err_q  <= timeout_err_d;
      en_read_q      <= en_read_d;
      start_frame_q  <= start_frame_d;
      stop_frame_q   <= stop_frame_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        state_d = enable ? S_GAP : S_IDLE;
      S_GAP:         state_d = (gap_cnt_q >= GAP_LAST) ? S_ISSUE : S_GAP;
      S_ISSUE:       state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (rd_rise_s) begin
          state_d = S_NEXT;
        end else if (frm_cnt_q >= TO_LAST) begin
          state_d = S_WAIT_PERIOD;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      // An enable drop anywhere in the frame sequence abandons the sample here.
      S_NEXT: begin
        if (abort_q || !enable) begin
          state_d = S_IDLE;
        end else if (idx_q) begin
          state_d = S_PUBLISH;
        end else begin
          state_d = S_GAP;
        end
      end
      S_PUBLISH:     state_d = S_WAIT_PERIOD;
      S_WAIT_PERIOD: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (per_cnt_q >= PERIOD_LAST) begin
          state_d = S_GAP;
        end else begin
          state_d = S_WAIT_PERIOD;
        end
      end
      default:       state_d = S_IDLE;
    endcase
  end

  // Counters, byte capture, sample assembly and flags.
  always_comb begin
    rd_done_prev_d = rd_bus.rd_done;

    if (sample_start_s) begin
      per_cnt_d = 21'd0;
    end else if ((state_q == S_IDLE) || (per_cnt_q == CNT_MAX)) begin
      per_cnt_d = per_cnt_q;
    end else begin
      per_cnt_d = per_cnt_q + 21'd1;
    end

    if (sample_start_s) begin
      idx_d = 1'b0;
    end else if ((state_q == S_NEXT) && (state_d == S_GAP)) begin
      idx_d = 1'b1;
    end else begin
      idx_d = idx_q;
    end

    gap_cnt_d = (state_q == S_GAP) ? (gap_cnt_q + 21'd1) : 21'd0;
    frm_cnt_d = (state_q == S_WAIT_DONE) ? (frm_cnt_q + 21'd1) : 21'd0;

    if ((state_q == S_WAIT_DONE) && rd_rise_s && !idx_q) begin
      byte0_d = rd_bus.rd_data;
    end else begin
      byte0_d = byte0_q;
    end
    if ((state_q == S_WAIT_DONE) && rd_rise_s && idx_q) begin
      byte1_d = rd_bus.rd_data;
    end else begin
      byte1_d = byte1_q;
    end

    if ((state_q == S_IDLE) || (state_q == S_WAIT_PERIOD)) begin
      abort_d = 1'b0;
    end else if (!enable) begin
      abort_d = 1'b1;
    end else begin
      abort_d = abort_q;
    end

    // Result moves with the pulse so both are seen together during PUBLISH.
    if (state_d == S_PUBLISH) begin
      result_d     = {byte0_q, byte1_q};
      sample_cnt_d = sample_cnt_q + 16'd1;
    end else begin
      result_d     = result_q;
      sample_cnt_d = sample_cnt_q;
    end

    if (frame_to_s) begin
      timeout_err_d = 1'b1;
    end else if ((state_q == S_IDLE) && !enable) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // Registered outputs decoded from the upcoming state.
  always_comb begin
    en_read_d      = (state_d == S_ISSUE) || (state_d == S_WAIT_DONE);
    start_frame_d  = (state_d == S_ISSUE);
    stop_frame_d   = (state_d == S_ISSUE) && idx_d;
    result_valid_d = (state_d == S_PUBLISH);
    busy_d         = (state_d != S_IDLE);
  end

  assign rd_bus.en_read     = en_read_q;
  assign rd_bus.start_frame = start_frame_q;
  assign rd_bus.stop_frame  = stop_frame_q;
  assign result             = result_q;
  assign result_valid       = result_valid_q;
  assign timeout_err        = timeout_err_q;
  assign busy               = busy_q;
  assign sample_cnt         = sample_cnt_q;

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Directed bench: behavioural read engine (0xA5 then 0x3C) driving two pollers,
// the second with its sample counter reset to 0xFFFF to exercise wrap-around.
module tb_i2c_sensor_poller;

  logic        clk_1MHz = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] result0, result1;
  logic        result_valid0, result_valid1;
  logic        timeout_err0, timeout_err1;
  logic        busy0, busy1;
  logic [15:0] sample_cnt0, sample_cnt1;

  i2c_sensor_poller_if if0 ();
  i2c_sensor_poller_if if1 ();

  assign if1.rd_done = if0.rd_done;
  assign if1.rd_data = if0.rd_data;

  i2c_sensor_poller #(.PERIOD_US(1000), .GAP_US(20), .TIMEOUT_US(500)) dut0 (
    .clk_1MHz    (clk_1MHz),
    .rst_n       (rst_n),
    .enable      (enable),
    .rd_bus      (if0),
    .result      (result0),
    .result_valid(result_valid0),
    .timeout_err (timeout_err0),
    .busy        (busy0),
    .sample_cnt  (sample_cnt0)
  );

  i2c_sensor_poller #(.PERIOD_US(1000), .GAP_US(20), .TIMEOUT_US(500),
                      .CNT_RST_VAL(16'hFFFF)) dut1 (
    .clk_1MHz    (clk_1MHz),
    .rst_n       (rst_n),
    .enable      (enable),
    .rd_bus      (if1),
    .result      (result1),
    .result_valid(result_valid1),
    .timeout_err (timeout_err1),
    .busy        (busy1),
    .sample_cnt  (sample_cnt1)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  int cyc = 0;
  always @(posedge clk_1MHz) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read-engine model: answers each start_frame after eng_lat cycles,
  // holding rd_done for eng_hold cycles; byte chosen by stop_frame.
  int   eng_lat  = 5;
  int   eng_hold = 3;
  bit   eng_on   = 1'b1;
  initial begin
    if0.rd_done = 1'b0;
    if0.rd_data = 8'h00;
    forever begin
      @(negedge clk_1MHz);
      if (eng_on && if0.start_frame) begin
        logic [7:0] b;
        b = if0.stop_frame ? 8'h3C : 8'hA5;
        repeat (eng_lat) @(negedge clk_1MHz);
        if0.rd_data = b;
        if0.rd_done = 1'b1;
        repeat (eng_hold) @(negedge clk_1MHz);
        if0.rd_done = 1'b0;
        if0.rd_data = 8'h00;
      end
    end
  end

  int   cnt_start, cnt_stop, cnt_valid;
  int   start_cyc [4];
  int   val_cyc [8];
  int   to_cyc, en_fall_cyc;
  bit   to_seen;
  logic en_prev = 1'b0;

  always @(negedge clk_1MHz) begin
    if (if0.start_frame) begin
      if (cnt_start < 4) start_cyc[cnt_start] = cyc;
      cnt_start++;
      if (if0.stop_frame) cnt_stop++;
    end
    if (result_valid0) begin
      if (cnt_valid < 8) val_cyc[cnt_valid] = cyc;
      cnt_valid++;
    end
    if (timeout_err0 && !to_seen) begin
      to_seen = 1'b1;
      to_cyc  = cyc;
    end
    if (en_prev && !if0.en_read) en_fall_cyc = cyc;
    en_prev = if0.en_read;
  end

  task automatic clear_mon();
    cnt_start   = 0;
    cnt_stop    = 0;
    cnt_valid   = 0;
    to_seen     = 1'b0;
    to_cyc      = -1;
    en_fall_cyc = -1;
    for (int i = 0; i < 4; i++) start_cyc[i] = -1;
    for (int i = 0; i < 8; i++) val_cyc[i] = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_1MHz);
    rst_n = 1'b1;
    @(negedge clk_1MHz);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_1MHz);
  endtask

  task automatic wait_valid(input int n, input int budget);
    int k;
    k = 0;
    while ((cnt_valid < n) && (k < budget)) begin
      @(negedge clk_1MHz);
      k++;
    end
  endtask

  task automatic wait_start(input int n, input int budget);
    int k;
    k = 0;
    while ((cnt_start < n) && (k < budget)) begin
      @(negedge clk_1MHz);
      k++;
    end
  endtask

  int c0;

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk_1MHz);
    rst_n = 1'b1;
    @(negedge clk_1MHz);

    check_eq("rst_busy",        {31'd0, busy0},         32'd0);
    check_eq("rst_en_read",     {31'd0, if0.en_read},   32'd0);
    check_eq("rst_start",       {31'd0, if0.start_frame}, 32'd0);
    check_eq("rst_valid",       {31'd0, result_valid0}, 32'd0);
    check_eq("rst_timeout",     {31'd0, timeout_err0},  32'd0);
    check_eq("rst_result",      {16'd0, result0},       32'h0000);
    check_eq("rst_cnt",         {16'd0, sample_cnt0},   32'd0);
    check_eq("rst_cnt_preload", {16'd0, sample_cnt1},   32'h0000_FFFF);

    // Single sample: GAP(20)+ISSUE, 5 wait cycles, NEXT, twice, then PUBLISH.
    clear_mon();
    c0 = cyc;
    enable = 1'b1;
    wait_valid(1, 2000);
    repeat (2) @(negedge clk_1MHz);
    enable = 1'b0;
    repeat (5) @(negedge clk_1MHz);
    check_eq("t1_starts",     cnt_start,           32'd2);
    check_eq("t1_stops",      cnt_stop,            32'd1);
    check_eq("t1_start0_cyc", start_cyc[0] - c0,   32'd21);
    check_eq("t1_start1_cyc", start_cyc[1] - c0,   32'd48);
    check_eq("t1_valid_cyc",  val_cyc[0] - c0,     32'd55);
    check_eq("t1_valids",     cnt_valid,           32'd1);
    check_eq("t1_result",     {16'd0, result0},    32'h0000_A53C);
    check_eq("t1_cnt",        {16'd0, sample_cnt0}, 32'd1);
    check_eq("t1_idle",       {31'd0, busy0},      32'd0);

    // Continuous polling for 3500 cycles: pulses at +55, +1055, +2055, +3055.
    do_reset();
    clear_mon();
    c0 = cyc;
    enable = 1'b1;
    wait_until(c0 + 3500);
    enable = 1'b0;
    repeat (5) @(negedge clk_1MHz);
    check_eq("t2_valids",   cnt_valid,              32'd4);
    check_eq("t2_first",    val_cyc[0] - c0,        32'd55);
    check_eq("t2_space1",   val_cyc[1] - val_cyc[0], 32'd1000);
    check_eq("t2_space2",   val_cyc[2] - val_cyc[1], 32'd1000);
    check_eq("t2_space3",   val_cyc[3] - val_cyc[2], 32'd1000);
    check_eq("t2_cnt",      {16'd0, sample_cnt0},   32'd4);
    check_eq("t2_result",   {16'd0, result0},       32'h0000_A53C);
    check_eq("t2_no_to",    {31'd0, timeout_err0},  32'd0);
    check_eq("t2_idle",     {31'd0, busy0},         32'd0);

    // Engine silent: 500 WAIT_DONE cycles after the 1-cycle ISSUE, then error.
    do_reset();
    eng_on = 1'b0;
    clear_mon();
    c0 = cyc;
    enable = 1'b1;
    wait_start(2, 1200);
    enable = 1'b0;
    check_eq("t3_to_delay", to_cyc - start_cyc[0],       32'd501);
    check_eq("t3_period",   start_cyc[1] - start_cyc[0], 32'd1000);
    check_eq("t3_stops",    cnt_stop,                    32'd0);
    check_eq("t3_err",      {31'd0, timeout_err0},       32'd1);
    repeat (600) @(negedge clk_1MHz);
    check_eq("t3_valids",   cnt_valid,                   32'd0);
    check_eq("t3_result",   {16'd0, result0},            32'h0000);
    check_eq("t3_err_clr",  {31'd0, timeout_err0},       32'd0);
    check_eq("t3_idle",     {31'd0, busy0},              32'd0);
    eng_on = 1'b1;

    // Enable dropped while byte 0 is outstanding; engine answers 30 cycles later.
    do_reset();
    eng_lat = 30;
    clear_mon();
    c0 = cyc;
    enable = 1'b1;
    wait_until(c0 + 30);
    enable = 1'b0;
    wait_until(c0 + 40);
    check_eq("t4_en_hold", {31'd0, if0.en_read}, 32'd1);
    wait_until(c0 + 60);
    check_eq("t4_en_fall", en_fall_cyc - c0,     32'd52);
    check_eq("t4_idle",    {31'd0, busy0},       32'd0);
    repeat (200) @(negedge clk_1MHz);
    check_eq("t4_starts",  cnt_start,            32'd1);
    check_eq("t4_valids",  cnt_valid,            32'd0);
    check_eq("t4_cnt",     {16'd0, sample_cnt0}, 32'd0);
    eng_lat = 5;

    // One-cycle reset pulse in WAIT_DONE of the second sample.
    do_reset();
    clear_mon();
    c0 = cyc;
    enable = 1'b1;
    wait_valid(1, 2000);
    wait_start(3, 1200);
    repeat (2) @(negedge clk_1MHz);
    check_eq("t5_pre_en",  {31'd0, if0.en_read}, 32'd1);
    check_eq("t5_pre_cnt", {16'd0, sample_cnt0}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk_1MHz);
    check_eq("t5_busy",    {31'd0, busy0},       32'd0);
    check_eq("t5_en",      {31'd0, if0.en_read}, 32'd0);
    check_eq("t5_cnt",     {16'd0, sample_cnt0}, 32'd0);
    check_eq("t5_result",  {16'd0, result0},     32'h0000);
    rst_n  = 1'b1;
    enable = 1'b0;
    repeat (20) @(negedge clk_1MHz);

    // rd_done held 11 cycles; preloaded counter wraps on publish.
    do_reset();
    eng_hold = 11;
    clear_mon();
    c0 = cyc;
    enable = 1'b1;
    wait_valid(1, 2000);
    repeat (2) @(negedge clk_1MHz);
    enable = 1'b0;
    repeat (5) @(negedge clk_1MHz);
    check_eq("t6_valids",  cnt_valid,            32'd1);
    check_eq("t6_lat",     val_cyc[0] - c0,      32'd55);
    check_eq("t6_result",  {16'd0, result0},     32'h0000_A53C);
    check_eq("t6_cnt",     {16'd0, sample_cnt0}, 32'd1);
    check_eq("t6_wrap",    {16'd0, sample_cnt1}, 32'd0);

    // rd_done still high when byte 1's WAIT_DONE starts: not a completion.
    do_reset();
    eng_hold = 40;
    clear_mon();
    c0 = cyc;
    enable = 1'b1;
    wait_until(c0 + 600);
    enable = 1'b0;
    check_eq("t7_starts",  cnt_start,             32'd2);
    check_eq("t7_valids",  cnt_valid,             32'd0);
    check_eq("t7_to_cyc",  to_cyc - c0,           32'd549);
    check_eq("t7_err",     {31'd0, timeout_err0}, 32'd1);
    eng_hold = 3;
    repeat (20) @(negedge clk_1MHz);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
